// File: rtl/ddr_nibble_packer.sv
// Packs rising/falling-edge nibble pairs LSB-first into words and presents them
// through a single-entry valid/ready output register, with flush for partial words.
module ddr_nibble_packer #(
    parameter int NIB_W         = 4,
    parameter int NIBS_PER_WORD = 4,
    parameter int CNT_W         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NIB_W-1:0]                 din_rise,
    input  logic [NIB_W-1:0]                 din_fall,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [NIB_W*NIBS_PER_WORD-1:0]   out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_partial,
    output logic [CNT_W-1:0]                 word_cnt
);

    localparam int PAIRS  = NIBS_PER_WORD / 2;
    localparam int WORD_W = NIB_W * NIBS_PER_WORD;
    localparam int PC_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [PC_W-1:0] LAST_PAIR = PC_W'(PAIRS - 1);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [PC_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_partial_q, out_partial_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    logic              last_pair_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              xfer_s;
    logic              can_load_s;
    logic              word_done_s;
    logic              has_data_s;
    logic              partial_want_s;
    logic              load_s;
    logic [WORD_W-1:0] acc_ins_s;

    // Handshake decode; the output register may reload in the same cycle it is drained.
    always_comb begin
        last_pair_s    = (pair_cnt_q == LAST_PAIR);
        xfer_s         = out_valid_q & out_ready;
        can_load_s     = ~out_valid_q | out_ready;
        in_ready_s     = ~flush_pend_q & ~(last_pair_s & out_valid_q & ~out_ready);
        accept_s       = in_valid & in_ready_s;
        word_done_s    = accept_s & last_pair_s;
        has_data_s     = (pair_cnt_q != {PC_W{1'b0}}) | accept_s;
        // A pending flush blocks accepts, so it never coincides with a completing pair.
        partial_want_s = flush_pend_q | (flush & has_data_s & ~word_done_s);
        load_s         = word_done_s | (partial_want_s & can_load_s);
    end

    // Accumulator with the current pair merged into nibbles 2k and 2k+1.
    always_comb begin
        acc_ins_s = acc_q;
        for (int k = 0; k < PAIRS; k++) begin
            acc_ins_s[2*k*NIB_W +: NIB_W] =
                (accept_s && (pair_cnt_q == PC_W'(k))) ? din_rise : acc_q[2*k*NIB_W +: NIB_W];
            acc_ins_s[(2*k+1)*NIB_W +: NIB_W] =
                (accept_s && (pair_cnt_q == PC_W'(k))) ? din_fall : acc_q[(2*k+1)*NIB_W +: NIB_W];
        end
    end

    // Next-state for accumulator, flush tracking, output register and word counter.
    always_comb begin
        acc_d         = acc_q;
        pair_cnt_d    = pair_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_partial_d = out_partial_q;
        word_cnt_d    = word_cnt_q;
        flush_pend_d  = partial_want_s & ~can_load_s;

        if (load_s) begin
            acc_d      = {WORD_W{1'b0}};
            pair_cnt_d = {PC_W{1'b0}};
        end else if (accept_s) begin
            acc_d      = acc_ins_s;
            pair_cnt_d = pair_cnt_q + PC_W'(1);
        end else begin
            acc_d      = acc_q;
            pair_cnt_d = pair_cnt_q;
        end

        if (load_s) begin
            out_data_d    = acc_ins_s;
            out_valid_d   = 1'b1;
            out_partial_d = ~word_done_s;
        end else if (xfer_s) begin
            out_valid_d   = 1'b0;
        end else begin
            out_valid_d   = out_valid_q;
        end

        if (xfer_s) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // State registers with synchronous reset that discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= {WORD_W{1'b0}};
            pair_cnt_q    <= {PC_W{1'b0}};
            flush_pend_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= {WORD_W{1'b0}};
            out_partial_q <= 1'b0;
            word_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            acc_q         <= acc_d;
            pair_cnt_q    <= pair_cnt_d;
            flush_pend_q  <= flush_pend_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_partial_q <= out_partial_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_partial = out_partial_q;
    assign word_cnt    = word_cnt_q;

endmodule
